// File: rtl/kfpga_config_loader_if.sv
// -----------------------------------------------------------------------------
// kfpga_config_loader_if
//   Valid/ready word stream that carries the configuration bitstream into the
//   kFPGA config loader.
//
//   Signals:
//     s_data   bitstream word, bit 0 is shifted into the chain first
//     s_valid  s_data is valid
//     s_ready  loader accepts the word when s_valid & s_ready
//
//   Modports:
//     master   bitstream source (drives data/valid, observes ready)
//     slave    loader side      (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface kfpga_config_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/kfpga_config_loader.sv
// -----------------------------------------------------------------------------
// kfpga_config_loader
//   Bitstream loader for a WIDTH x HEIGHT kFPGA core ringed by IO tiles.
//   Words arrive over a valid/ready stream and are serialised LSB-first into
//   the core config chain (west IO, south IO, logic tiles, north IO, east IO).
//   The loader clears the chain before shifting and keeps the core's user
//   enable low until a load completes.
//
//   Chain length = WIDTH*HEIGHT*TILE_BITS + 2*(WIDTH+HEIGHT)*IO_TILE_BITS bits,
//   delivered in ceil(chain length / DATA_WIDTH) words; the unused upper bits of
//   the last word are discarded.
//
//   Optional feature (compile-time macro KFPGA_CONFIG_CRC_EN):
//     A CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over every shifted bit.
//     After the last chain bit one extra word is fetched; its low 16 bits
//     (all of it when DATA_WIDTH < 16) must match the CRC. A mismatch raises
//     the sticky error flag and keeps core_enable low. Without the macro there
//     is no check word and error is constant 0.
//
//   Ports:
//     clock          system clock (the core config clock is tied to it)
//     reset          synchronous, active-high; aborts any load in progress
//     start          begin a load, sampled only while idle
//     s              bitstream stream, slave side (s_data / s_valid / s_ready)
//     config_out     serial data to the core config_in
//     config_enable  chain shift enable, one bit per cycle while high
//     config_nreset  chain clear, active-low
//     core_enable    core user enable, high only after a successful load
//     busy           high whenever a load is in progress
//     done           one-cycle pulse at the end of a load
//     error          sticky CRC mismatch flag, cleared by the next start
// -----------------------------------------------------------------------------
module kfpga_config_loader #(
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 8,
  parameter int TILE_BITS    = 64,
  parameter int IO_TILE_BITS = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  kfpga_config_loader_if.slave   s,
  output logic                   config_out,
  output logic                   config_enable,
  output logic                   config_nreset,
  output logic                   core_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int CHAIN_LENGTH = WIDTH * HEIGHT * TILE_BITS
                              + 2 * (WIDTH + HEIGHT) * IO_TILE_BITS;
  localparam int BIT_W  = $clog2(CHAIN_LENGTH + 1);
  localparam int WBIT_W = $clog2(DATA_WIDTH);
  localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LENGTH - 1);
  localparam logic [WBIT_W-1:0] LAST_WBIT = WBIT_W'(DATA_WIDTH - 1);
  localparam logic [CLR_W-1:0]  LAST_CLR  = CLR_W'(CLEAR_CYCLES - 1);

`ifdef KFPGA_CONFIG_CRC_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_SHIFT, ST_CHECK, ST_FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_SHIFT, ST_FINISH
  } state_t;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shreg;     // remaining bits of the current word
  logic [BIT_W-1:0]        bit_cnt;   // chain bits shifted so far
  logic [WBIT_W-1:0]       word_bit;  // bit position inside the current word
  logic [CLR_W-1:0]        clr_cnt;

`ifdef KFPGA_CONFIG_CRC_EN
  // A narrow stream word can only carry the low DATA_WIDTH bits of the CRC.
  localparam int CRC_CMP_W = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        crc_fb;
  logic        crc_match;

  // config_out is the bit leaving the loader this cycle, so the CRC tracks
  // exactly what the chain sees.
  // NOTE: every variable gets a value before any conditional update, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    crc_fb   = crc[15] ^ config_out;
    crc_next = {crc[14:0], 1'b0};
    if (crc_fb) crc_next = crc_next ^ 16'h1021;
  end

  assign crc_match = (s.s_data[CRC_CMP_W-1:0] == crc[CRC_CMP_W-1:0]);
`else
  assign error = 1'b0;
`endif

  // NOTE: state and every registered output use non-blocking assignments so
  // all of them update together from values sampled at the same clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      s.s_ready     <= 1'b0;
      config_out    <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b1;
      core_enable   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      word_bit      <= '0;
      clr_cnt       <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
      crc           <= 16'hFFFF;
      error         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_CLEAR;
            busy          <= 1'b1;
            core_enable   <= 1'b0;
            config_nreset <= 1'b0;
            clr_cnt       <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
            error         <= 1'b0;
`endif
          end
        end

        // config_nreset went low on entry; it stays low for one cycle per
        // count value, i.e. CLEAR_CYCLES cycles in total.
        ST_CLEAR: begin
          bit_cnt  <= '0;
          word_bit <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
          crc      <= 16'hFFFF;
`endif
          if (clr_cnt == LAST_CLR) begin
            config_nreset <= 1'b1;
            s.s_ready     <= 1'b1;
            state         <= ST_FETCH;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        // s_ready is high for the whole of FETCH. Bit 0 is presented on
        // config_out straight away so the first SHIFT cycle already drives it.
        ST_FETCH: begin
          if (s.s_valid && s.s_ready) begin
            s.s_ready     <= 1'b0;
            config_out    <= s.s_data[0];
            config_enable <= 1'b1;
            shreg         <= s.s_data >> 1;
            state         <= ST_SHIFT;
          end
        end

        // Each cycle here, config_out/config_enable carry one chain bit.
        // The decision below is about the bit being shifted right now.
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
`ifdef KFPGA_CONFIG_CRC_EN
          crc     <= crc_next;
`endif
          if (bit_cnt == LAST_BIT) begin
            // Chain full: drop whatever is left of the last word.
            config_enable <= 1'b0;
            config_out    <= 1'b0;
            word_bit      <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
            s.s_ready     <= 1'b1;
            state         <= ST_CHECK;
`else
            done          <= 1'b1;
            core_enable   <= 1'b1;
            state         <= ST_FINISH;
`endif
          end else if (word_bit == LAST_WBIT) begin
            config_enable <= 1'b0;
            config_out    <= 1'b0;
            word_bit      <= '0;
            s.s_ready     <= 1'b1;
            state         <= ST_FETCH;
          end else begin
            word_bit   <= word_bit + 1'b1;
            config_out <= shreg[0];
            shreg      <= shreg >> 1;
          end
        end

`ifdef KFPGA_CONFIG_CRC_EN
        ST_CHECK: begin
          if (s.s_valid && s.s_ready) begin
            s.s_ready <= 1'b0;
            done      <= 1'b1;
            state     <= ST_FINISH;
            if (crc_match) core_enable <= 1'b1;
            else           error       <= 1'b1;
          end
        end
`endif

        // done and core_enable were raised on entry; this cycle is the pulse.
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// -----------------------------------------------------------------------------
// tb_kfpga_config_loader
//   Self-checking bench for kfpga_config_loader with a 2x2 grid, 5-bit logic
//   tiles, 3-bit IO tiles and 8-bit words (44-bit chain, 6 words).
//   A table of load scenarios (random bitstreams, stalls, stray start pulses,
//   truncated last word, CRC corruption) is run against a reference that
//   builds the expected chain contents directly from the words, followed by a
//   hand-written reset-in-the-middle-of-a-load sequence.
//   Define KFPGA_CONFIG_CRC_EN for both bench and RTL to cover the CRC check.
// -----------------------------------------------------------------------------
module tb_kfpga_config_loader;

  localparam int W     = 2;
  localparam int H     = 2;
  localparam int TB    = 5;
  localparam int IOB   = 3;
  localparam int DW    = 8;
  localparam int CLR   = 4;
  localparam int CHAIN = W * H * TB + 2 * (W + H) * IOB;   // 44
  localparam int WORDS = (CHAIN + DW - 1) / DW;            // 6
`ifdef KFPGA_CONFIG_CRC_EN
  localparam int NWORDS = WORDS + 1;
`else
  localparam int NWORDS = WORDS;
`endif

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic config_out, config_enable, config_nreset;
  logic core_enable, busy, done, error;

  kfpga_config_loader_if #(.DATA_WIDTH(DW)) sif ();

  kfpga_config_loader #(
    .WIDTH(W), .HEIGHT(H), .TILE_BITS(TB), .IO_TILE_BITS(IOB),
    .DATA_WIDTH(DW), .CLEAR_CYCLES(CLR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .s             (sif),
    .config_out    (config_out),
    .config_enable (config_enable),
    .config_nreset (config_nreset),
    .core_enable   (core_enable),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: records every chain bit and counts the side effects of a load.
  // ---------------------------------------------------------------------------
  bit   mon_en = 1'b0;
  bit   got[$];
  int   nres_cnt, done_cnt, overlap_cnt, ce_shift_cnt, stall_bad;

  always @(negedge clock) begin
    if (mon_en) begin
      if (config_enable)                got.push_back(config_out);
      if (!config_nreset)               nres_cnt++;
      if (done)                         done_cnt++;
      if (sif.s_ready && config_enable) overlap_cnt++;
      if (core_enable && config_enable) ce_shift_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: the chain receives word k bit j as chain bit k*DW+j,
  // cut off after CHAIN bits.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] words [NWORDS];
  bit            abort;

  function automatic logic [63:0] exp_stream();
    logic [63:0] v = '0;
    for (int i = 0; i < CHAIN; i++) v[i] = words[i / DW][i % DW];
    return v;
  endfunction

  function automatic logic [15:0] crc16(input logic [63:0] v);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < CHAIN; i++) begin
      if (c[15] ^ v[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [63:0] got_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < got.size() && i < 64; i++) v[i] = got[i];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Source: offers one word, optionally after holding s_valid low for
  // pre_stall cycles of FETCH. Returns just after the accepting edge.
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [DW-1:0] d, input int pre_stall);
    bit hs = 1'b0;
    if (pre_stall > 0) begin
      int n = 0;
      while (!sif.s_ready && !abort && n < 200) begin
        @(negedge clock);
        n++;
      end
      repeat (pre_stall) begin
        @(posedge clock); #1;
        if (config_enable) stall_bad++;
      end
    end
    sif.s_data  = d;
    sif.s_valid = 1'b1;
    for (int n = 0; n < 200 && !abort; n++) begin
      @(negedge clock);
      if (sif.s_ready) begin
        @(posedge clock); #1;
        hs = 1'b1;
        break;
      end
    end
    sif.s_valid = 1'b0;
    if (!hs && !abort) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_load(input int stall_word, input int stall_len, input bit extra_start);
    int n;
    got.delete();
    nres_cnt = 0; done_cnt = 0; overlap_cnt = 0; ce_shift_cnt = 0; stall_bad = 0;
    abort  = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      if (abort) break;
      send_word(words[w], (w == stall_word) ? stall_len : 0);
      if (extra_start && w == 1) begin
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
      end
    end
    n = 0;
    while (busy && !abort && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy && !abort) check("busy_timeout", 64'd0, 64'd1);
    @(negedge clock);
    @(negedge clock);
    mon_en      = 1'b0;
    sif.s_valid = 1'b0;
    start       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario table
  // ---------------------------------------------------------------------------
  typedef struct {
    string name;
    int    stall_word;
    int    stall_len;
    bit    new_data;
    bit    force_f5;
    bit    extra_start;
    bit    crc_flip;
    int    exp_bits;
    int    exp_nres;
    int    exp_dones;
    bit    exp_core;
    bit    exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic prepare(input vec_t v);
    if (v.new_data)
      for (int w = 0; w < WORDS; w++) words[w] = DW'($urandom);
    if (v.force_f5) words[WORDS-1] = 8'hF5;
`ifdef KFPGA_CONFIG_CRC_EN
    begin
      logic [15:0] c = crc16(exp_stream());
      words[WORDS] = c[DW-1:0] ^ (v.crc_flip ? 8'h01 : 8'h00);
    end
`endif
  endtask

  task automatic check_load(input vec_t v);
    logic [63:0] g = got_vec();
    check({v.name, "_enables"},   got.size(),   v.exp_bits);
    check({v.name, "_stream"},    g,            exp_stream());
    check({v.name, "_nreset"},    nres_cnt,     v.exp_nres);
    check({v.name, "_done"},      done_cnt,     v.exp_dones);
    check({v.name, "_core_en"},   core_enable,  v.exp_core);
    check({v.name, "_error"},     error,        v.exp_err);
    check({v.name, "_busy"},      busy,         1'b0);
    check({v.name, "_ready_ovl"}, overlap_cnt,  0);
    check({v.name, "_ce_shift"},  ce_shift_cnt, 0);
    check({v.name, "_stall_en"},  stall_bad,    0);
    if (v.force_f5) check({v.name, "_tail"}, g[CHAIN-1 -: 4], 4'b0101);
  endtask

  // Packed view of every output for reset-value checks.
  function automatic logic [7:0] out_vec();
    return {sif.s_ready, config_out, config_enable, config_nreset,
            core_enable, busy, done, error};
  endfunction
  localparam logic [7:0] RESET_OUTS = 8'b0001_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    abort       = 1'b0;

    vecs.push_back('{"nominal",    -1,  0, 1'b1, 1'b0, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
    vecs.push_back('{"starve",      2, 10, 1'b0, 1'b0, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
    vecs.push_back('{"partial",    -1,  0, 1'b1, 1'b1, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
    vecs.push_back('{"busy_start", -1,  0, 1'b1, 1'b0, 1'b1, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
    vecs.push_back('{"rand_stall", int'($urandom_range(0, WORDS - 1)),
                     int'($urandom_range(1, 6)),
                                         1'b1, 1'b0, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
    vecs.push_back('{"last_stall", WORDS - 1, 3,
                                         1'b1, 1'b1, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
`ifdef KFPGA_CONFIG_CRC_EN
    vecs.push_back('{"crc_bad",    -1,  0, 1'b1, 1'b0, 1'b0, 1'b1, CHAIN, CLR, 1, 1'b0, 1'b1});
    vecs.push_back('{"crc_good",   -1,  0, 1'b1, 1'b0, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0});
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", out_vec(), RESET_OUTS);
    reset = 1'b0;
    @(negedge clock);
    check("idle_outputs", out_vec(), RESET_OUTS);

    foreach (vecs[i]) begin
      prepare(vecs[i]);
      run_load(vecs[i].stall_word, vecs[i].stall_len, vecs[i].extra_start);
      check_load(vecs[i]);
    end

    // Reset while bit 20 is on its way into the chain.
    begin
      vec_t v = '{"reload", -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, CHAIN, CLR, 1, 1'b1, 1'b0};
      bit   hit = 1'b0;
      prepare(v);
      fork
        run_load(-1, 0, 1'b0);
        begin
          @(posedge clock);
          for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (got.size() >= 20) begin
              hit   = 1'b1;
              reset = 1'b1;
              abort = 1'b1;
              break;
            end
          end
          @(negedge clock);
          check("midload_reset_seen", hit, 1'b1);
          check("midload_reset_outs", out_vec(), RESET_OUTS);
          reset = 1'b0;
        end
      join
      @(negedge clock);
      check("after_abort_idle", out_vec(), RESET_OUTS);
      run_load(-1, 0, 1'b0);
      check_load(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
